// File: rtl/ps2_line_buffer.sv
// ---------------------------------------------------------------------------
// ps2_line_buffer
//
// Purpose:
//   Line editor between ps2_cleaner and display_controller. Cleaned key codes
//   are assembled into an editable line of up to LINE_CHARS characters.
//   Backspace removes the last character. Enter commits a non-empty line to
//   ps2_line_content and raises ps2_line_ready, which stays high until the
//   consumer acknowledges with line_ack. The live edit buffer is exported so
//   the screen can show the line being typed.
//
// Packing:
//   Character index i lives in bits [8*(LINE_CHARS-i)-1 -: 8], so index 0 is
//   the most significant byte. Unused slots hold PAD_CHAR.
//
// Optional feature (compile-time macro):
//   PS2_LINE_UPPERCASE_EN - when defined, 'a'..'z' are stored as 'A'..'Z'.
//   Key classification is the same in both builds.
//
// Ports:
//   clock            in   system clock
//   reset            in   asynchronous, active-high reset
//   input_character  in   [7:0] ASCII code from ps2_cleaner
//   input_made       in   key-valid strobe (level or pulse, rising edge used)
//   line_ack         in   consumer has taken ps2_line_content
//   edit_content     out  [8*LINE_CHARS-1:0] line being typed, packed
//   edit_length      out  [LEN_W-1:0] number of valid characters in edit_content
//   ps2_line_content out  [8*LINE_CHARS-1:0] last committed line, packed
//   ps2_line_ready   out  committed line valid and not yet acknowledged
//   line_full        out  edit_length == LINE_CHARS (combinational)
//   commit_overrun   out  sticky: an Enter was dropped while a line was pending
// ---------------------------------------------------------------------------
module ps2_line_buffer #(
    parameter int          LINE_CHARS = 32,
    parameter logic [7:0]  PAD_CHAR   = 8'h20,
    parameter int          LEN_W      = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              input_character,
    input  logic                    input_made,
    input  logic                    line_ack,
    output logic [8*LINE_CHARS-1:0] edit_content,
    output logic [LEN_W-1:0]        edit_length,
    output logic [8*LINE_CHARS-1:0] ps2_line_content,
    output logic                    ps2_line_ready,
    output logic                    line_full,
    output logic                    commit_overrun
);

    localparam logic [LEN_W-1:0]        MAX_LEN  = LEN_W'(LINE_CHARS);
    localparam logic [LEN_W-1:0]        ONE_LEN  = LEN_W'(1);
    localparam logic [8*LINE_CHARS-1:0] PAD_LINE = {LINE_CHARS{PAD_CHAR}};

    localparam logic [7:0] KEY_BACKSPACE = 8'h08;
    localparam logic [7:0] KEY_ENTER     = 8'h0D;

    // EDIT: no committed line pending. HOLD: ps2_line_ready is high.
    typedef enum logic {
        EDIT = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    made_q;
    logic [8*LINE_CHARS-1:0] edit_q, edit_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [8*LINE_CHARS-1:0] line_q, line_d;
    logic                    overrun_q, overrun_d;

    logic                    key_event;
    logic                    is_printable;
    logic                    is_backspace;
    logic                    is_enter;
    logic                    enter_nonempty;
    logic [7:0]              stored_char;

    // One event per rising edge of input_made, so a held key never repeats.
    assign key_event      = input_made && !made_q;

    assign is_printable   = (input_character >= 8'h20) && (input_character <= 8'h7E);
    assign is_backspace   = (input_character == KEY_BACKSPACE);
    assign is_enter       = (input_character == KEY_ENTER);

    // An Enter on an empty line does nothing at all, not even an overrun.
    assign enter_nonempty = key_event && is_enter && (len_q != '0);

    // Byte actually written into the edit buffer for a printable key.
    always_comb begin
        stored_char = input_character;
`ifdef PS2_LINE_UPPERCASE_EN
        if ((input_character >= 8'h61) && (input_character <= 8'h7A)) begin
            stored_char = input_character - 8'h20;
        end
`endif
    end

    // Next-state logic for the edit buffer, the committed line and the FSM.
    // Editing is handled first; a commit then overrides the edit buffer,
    // which is safe because a single key event is either an edit or an Enter.
    always_comb begin
        state_d   = state_q;
        edit_d    = edit_q;
        len_d     = len_q;
        line_d    = line_q;
        overrun_d = overrun_q;

        if (key_event && is_printable && (len_q < MAX_LEN)) begin
            for (int i = 0; i < LINE_CHARS; i++) begin
                if (LEN_W'(i) == len_q) begin
                    edit_d[8*(LINE_CHARS-i)-1 -: 8] = stored_char;
                end
            end
            len_d = len_q + ONE_LEN;
        end else if (key_event && is_backspace && (len_q != '0)) begin
            for (int i = 0; i < LINE_CHARS; i++) begin
                if (LEN_W'(i) == (len_q - ONE_LEN)) begin
                    edit_d[8*(LINE_CHARS-i)-1 -: 8] = PAD_CHAR;
                end
            end
            len_d = len_q - ONE_LEN;
        end

        case (state_q)
            EDIT: begin
                if (enter_nonempty) begin
                    line_d  = edit_q;
                    edit_d  = PAD_LINE;
                    len_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // An ack frees the slot first, so a same-edge Enter can
                // commit straight into it and the line stays ready.
                if (line_ack) begin
                    state_d = EDIT;
                    if (enter_nonempty) begin
                        line_d  = edit_q;
                        edit_d  = PAD_LINE;
                        len_d   = '0;
                        state_d = HOLD;
                    end
                end else if (enter_nonempty) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = EDIT;
            end
        endcase
    end

    // State and datapath registers, cleared immediately by reset so a
    // partial line is thrown away.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= EDIT;
            made_q    <= 1'b0;
            edit_q    <= PAD_LINE;
            len_q     <= '0;
            line_q    <= PAD_LINE;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            made_q    <= input_made;
            edit_q    <= edit_d;
            len_q     <= len_d;
            line_q    <= line_d;
            overrun_q <= overrun_d;
        end
    end

    assign edit_content     = edit_q;
    assign edit_length      = len_q;
    assign ps2_line_content = line_q;
    assign ps2_line_ready   = (state_q == HOLD);
    assign commit_overrun   = overrun_q;
    assign line_full        = (len_q == MAX_LEN);

endmodule

// File: tb/tb_ps2_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_ps2_line_buffer
//
// Self-checking bench for ps2_line_buffer. A behavioural model tracks the
// edit line; every line the model expects to be committed is pushed onto a
// scoreboard queue when the Enter is driven and popped when the DUT shows
// the committed line.
// ---------------------------------------------------------------------------
module tb_ps2_line_buffer;

    localparam int N = 32;
    localparam logic [8*N-1:0] PAD_LINE = {N{8'h20}};

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [7:0]     input_character = 8'h00;
    logic           input_made = 1'b0;
    logic           line_ack = 1'b0;
    logic [8*N-1:0] edit_content;
    logic [5:0]     edit_length;
    logic [8*N-1:0] ps2_line_content;
    logic           ps2_line_ready;
    logic           line_full;
    logic           commit_overrun;

    int num_checks = 0;
    int num_errors = 0;

    // Reference model of the editor.
    logic [7:0]     m_buf [N];
    int             m_len;
    logic           m_ready;
    logic           m_overrun;
    logic [8*N-1:0] exp_q [$];

    ps2_line_buffer dut (
        .clock            (clock),
        .reset            (reset),
        .input_character  (input_character),
        .input_made       (input_made),
        .line_ack         (line_ack),
        .edit_content     (edit_content),
        .edit_length      (edit_length),
        .ps2_line_content (ps2_line_content),
        .ps2_line_ready   (ps2_line_ready),
        .line_full        (line_full),
        .commit_overrun   (commit_overrun)
    );

    always #5 clock = ~clock;

    // Hard stop in case anything stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [8*N-1:0] model_packed();
        logic [8*N-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[8*(N-i)-1 -: 8] = m_buf[i];
        return p;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_buf[i] = 8'h20;
        m_len     = 0;
        m_ready   = 1'b0;
        m_overrun = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_key(input logic [7:0] ch, input logic ack);
        logic [7:0] c;
        logic       committed;
        c = ch;
        committed = 1'b0;
`ifdef PS2_LINE_UPPERCASE_EN
        if (ch >= 8'h61 && ch <= 8'h7A) c = ch - 8'h20;
`endif
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            if (m_len < N) begin
                m_buf[m_len] = c;
                m_len++;
            end
        end else if (ch == 8'h08) begin
            if (m_len > 0) begin
                m_len--;
                m_buf[m_len] = 8'h20;
            end
        end else if (ch == 8'h0D && m_len > 0) begin
            if (!m_ready || ack) begin
                exp_q.push_back(model_packed());
                for (int i = 0; i < N; i++) m_buf[i] = 8'h20;
                m_len     = 0;
                m_ready   = 1'b1;
                committed = 1'b1;
            end else begin
                m_overrun = 1'b1;
            end
        end
        if (ack && m_ready && !committed) m_ready = 1'b0;
    endfunction

    task automatic press_key(input logic [7:0] ch, input logic ack);
        @(negedge clock);
        input_character = ch;
        input_made      = 1'b1;
        line_ack        = ack;
        model_key(ch, ack);
        @(negedge clock);
        input_made      = 1'b0;
        line_ack        = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clock);
        line_ack = 1'b1;
        if (m_ready) m_ready = 1'b0;
        @(negedge clock);
        line_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        num_checks++;
        if (edit_length !== 6'd0) begin
            num_errors++;
            $display("[TB] FAIL reset_len: got %0d expected 0", edit_length);
        end
        num_checks++;
        if (edit_content !== PAD_LINE) begin
            num_errors++;
            $display("[TB] FAIL reset_edit: got %h expected %h", edit_content, PAD_LINE);
        end
        num_checks++;
        if (ps2_line_content !== PAD_LINE) begin
            num_errors++;
            $display("[TB] FAIL reset_line: got %h expected %h", ps2_line_content, PAD_LINE);
        end
        num_checks++;
        if ({ps2_line_ready, commit_overrun, line_full} !== 3'b000) begin
            num_errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000",
                     {ps2_line_ready, commit_overrun, line_full});
        end
    endtask

    task automatic test_hi_commit();
        logic [8*N-1:0] exp;
        press_key(8'h48, 1'b0);
        num_checks++;
        if (edit_length !== 6'd1) begin
            num_errors++;
            $display("[TB] FAIL hi_len1: got %0d expected 1", edit_length);
        end
        press_key(8'h49, 1'b0);
        num_checks++;
        if (edit_length !== 6'd2) begin
            num_errors++;
            $display("[TB] FAIL hi_len2: got %0d expected 2", edit_length);
        end
        num_checks++;
        if (edit_content !== model_packed()) begin
            num_errors++;
            $display("[TB] FAIL hi_edit: got %h expected %h", edit_content, model_packed());
        end
        press_key(8'h0D, 1'b0);
        num_checks++;
        if (exp_q.size() == 0) begin
            num_errors++;
            $display("[TB] FAIL hi_queue: got 0 entries expected 1");
        end else begin
            exp = exp_q.pop_front();
            if (ps2_line_content !== exp) begin
                num_errors++;
                $display("[TB] FAIL hi_commit: got %h expected %h", ps2_line_content, exp);
            end
        end
        num_checks++;
        if (ps2_line_content !== {16'h4849, {30{8'h20}}}) begin
            num_errors++;
            $display("[TB] FAIL hi_literal: got %h expected 4849 then 20s", ps2_line_content);
        end
        num_checks++;
        if ({ps2_line_ready, edit_length} !== {1'b1, 6'd0}) begin
            num_errors++;
            $display("[TB] FAIL hi_ready_len: got %b/%0d expected 1/0", ps2_line_ready, edit_length);
        end
        num_checks++;
        if (edit_content !== PAD_LINE) begin
            num_errors++;
            $display("[TB] FAIL hi_edit_cleared: got %h expected %h", edit_content, PAD_LINE);
        end
        ack_pulse();
        num_checks++;
        if (ps2_line_ready !== 1'b0 || ps2_line_content !== {16'h4849, {30{8'h20}}}) begin
            num_errors++;
            $display("[TB] FAIL hi_ack: got ready=%b line=%h expected ready=0 line kept",
                     ps2_line_ready, ps2_line_content);
        end
    endtask

    task automatic test_backspace();
        logic [8*N-1:0] exp;
        press_key(8'h08, 1'b0);
        num_checks++;
        if (edit_length !== 6'd0) begin
            num_errors++;
            $display("[TB] FAIL bs_at_zero: got %0d expected 0", edit_length);
        end
        press_key(8'h41, 1'b0);
        press_key(8'h42, 1'b0);
        press_key(8'h08, 1'b0);
        num_checks++;
        if (edit_length !== 6'd1 || edit_content !== model_packed()) begin
            num_errors++;
            $display("[TB] FAIL bs_edit: got %0d/%h expected 1/%h",
                     edit_length, edit_content, model_packed());
        end
        press_key(8'h43, 1'b0);
        press_key(8'h0D, 1'b0);
        num_checks++;
        if (exp_q.size() == 0) begin
            num_errors++;
            $display("[TB] FAIL bs_queue: got 0 entries expected 1");
        end else begin
            exp = exp_q.pop_front();
            if (ps2_line_content !== exp || exp !== {16'h4143, {30{8'h20}}}) begin
                num_errors++;
                $display("[TB] FAIL bs_commit: got %h expected %h", ps2_line_content, exp);
            end
        end
        ack_pulse();
    endtask

    task automatic test_hold_high();
        @(negedge clock);
        input_character = 8'h41;
        input_made      = 1'b1;
        model_key(8'h41, 1'b0);
        repeat (10) @(negedge clock);
        input_made = 1'b0;
        @(negedge clock);
        num_checks++;
        if (edit_length !== 6'd1 || edit_content !== model_packed()) begin
            num_errors++;
            $display("[TB] FAIL hold_high: got %0d/%h expected 1/%h",
                     edit_length, edit_content, model_packed());
        end
        press_key(8'h08, 1'b0);
    endtask

    task automatic test_overflow();
        logic [8*N-1:0] snap;
        for (int k = 0; k < 31; k++) press_key(8'h41 + 8'(k % 26), 1'b0);
        num_checks++;
        if (line_full !== 1'b0 || edit_length !== 6'd31) begin
            num_errors++;
            $display("[TB] FAIL ovf_31: got full=%b len=%0d expected 0/31", line_full, edit_length);
        end
        press_key(8'h5A, 1'b0);
        num_checks++;
        if (line_full !== 1'b1 || edit_length !== 6'd32) begin
            num_errors++;
            $display("[TB] FAIL ovf_32: got full=%b len=%0d expected 1/32", line_full, edit_length);
        end
        snap = model_packed();
        press_key(8'h21, 1'b0);
        num_checks++;
        if (edit_length !== 6'd32 || edit_content !== snap) begin
            num_errors++;
            $display("[TB] FAIL ovf_33: got %0d/%h expected 32/%h", edit_length, edit_content, snap);
        end
        do_reset();
    endtask

    task automatic test_overrun();
        logic [8*N-1:0] exp;
        logic [8*N-1:0] x_line;
        x_line = {8'h58, {31{8'h20}}};
        press_key(8'h58, 1'b0);
        press_key(8'h0D, 1'b0);
        num_checks++;
        if (exp_q.size() == 0) begin
            num_errors++;
            $display("[TB] FAIL ovr_queue_x: got 0 entries expected 1");
        end else begin
            exp = exp_q.pop_front();
            if (ps2_line_content !== exp) begin
                num_errors++;
                $display("[TB] FAIL ovr_commit_x: got %h expected %h", ps2_line_content, exp);
            end
        end
        press_key(8'h59, 1'b0);
        press_key(8'h0D, 1'b0);
        num_checks++;
        if (commit_overrun !== 1'b1 || ps2_line_ready !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL ovr_flag: got overrun=%b ready=%b expected 1/1",
                     commit_overrun, ps2_line_ready);
        end
        num_checks++;
        if (ps2_line_content !== x_line || edit_length !== 6'd1) begin
            num_errors++;
            $display("[TB] FAIL ovr_kept: got %h/%0d expected %h/1", ps2_line_content, edit_length, x_line);
        end
        press_key(8'h0D, 1'b1);
        num_checks++;
        if (exp_q.size() == 0) begin
            num_errors++;
            $display("[TB] FAIL ovr_queue_y: got 0 entries expected 1");
        end else begin
            exp = exp_q.pop_front();
            if (ps2_line_content !== exp || exp !== {8'h59, {31{8'h20}}}) begin
                num_errors++;
                $display("[TB] FAIL ovr_commit_y: got %h expected %h", ps2_line_content, exp);
            end
        end
        num_checks++;
        if ({ps2_line_ready, commit_overrun, edit_length} !== {1'b1, 1'b1, 6'd0}) begin
            num_errors++;
            $display("[TB] FAIL ovr_ack_enter: got ready=%b overrun=%b len=%0d expected 1/1/0",
                     ps2_line_ready, commit_overrun, edit_length);
        end
    endtask

    task automatic test_reset_midline();
        press_key(8'h31, 1'b0);
        press_key(8'h32, 1'b0);
        press_key(8'h33, 1'b0);
        num_checks++;
        if (edit_length !== 6'd3 || ps2_line_ready !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL mid_pre: got len=%0d ready=%b expected 3/1", edit_length, ps2_line_ready);
        end
        @(negedge clock);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        num_checks++;
        if (edit_length !== 6'd0 || edit_content !== PAD_LINE || ps2_line_content !== PAD_LINE) begin
            num_errors++;
            $display("[TB] FAIL mid_async_data: got len=%0d edit=%h line=%h expected 0/pad/pad",
                     edit_length, edit_content, ps2_line_content);
        end
        num_checks++;
        if ({ps2_line_ready, commit_overrun, line_full} !== 3'b000) begin
            num_errors++;
            $display("[TB] FAIL mid_async_flags: got %b expected 000",
                     {ps2_line_ready, commit_overrun, line_full});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_case_map();
        logic [7:0] want;
`ifdef PS2_LINE_UPPERCASE_EN
        want = 8'h51;
`else
        want = 8'h71;
`endif
        press_key(8'h71, 1'b0);
        num_checks++;
        if (edit_content[8*N-1 -: 8] !== want || edit_content !== model_packed()) begin
            num_errors++;
            $display("[TB] FAIL case_map: got %h expected %h", edit_content[8*N-1 -: 8], want);
        end
    endtask

    initial begin
        model_reset();
        $display("[TB] starting ps2_line_buffer bench");
        test_reset();
        test_hi_commit();
        test_backspace();
        test_hold_high();
        test_overflow();
        test_overrun();
        test_reset_midline();
        test_case_map();
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/ps2_line_buffer.md
Name: ps2_line_buffer

Overview:
- Sits between ps2_cleaner and display_controller.
- Consumes cleaned key characters (input_character / input_made) and assembles an editable line of up to LINE_CHARS ASCII characters.
- On Enter, commits the line to ps2_line_content and raises ps2_line_ready, which display_controller holds until it acknowledges.
- The live edit buffer is exported so the screen can show the line being typed.

Parameters:
- LINE_CHARS, 32, maximum characters per line (content buses are 8*LINE_CHARS bits).
- PAD_CHAR, 8'h20, fill byte for unused character slots.
- LEN_W, 6, width of edit_length; must be at least clog2(LINE_CHARS+1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- input_character  in  8  ASCII code from ps2_cleaner.
- input_made  in  1  key-valid strobe from ps2_cleaner; level or pulse, rising edge is used.
- line_ack  in  1  consumer has taken ps2_line_content.
- edit_content  out  8*LINE_CHARS  line being typed, packed.
- edit_length  out  LEN_W  number of valid characters in edit_content.
- ps2_line_content  out  8*LINE_CHARS  last committed line, packed.
- ps2_line_ready  out  1  committed line is valid and not yet acknowledged.
- line_full  out  1  edit_length == LINE_CHARS.
- commit_overrun  out  1  sticky: an Enter was dropped because ps2_line_ready was still high.

Behaviour:
- Packing: character index i occupies bits [8*(LINE_CHARS-i)-1 -: 8]. Index 0 is the MSB byte. Slots at index >= edit_length hold PAD_CHAR.
- Reset (async, immediate) drives:
  - edit_content and ps2_line_content to all PAD_CHAR.
  - edit_length to 0.
  - ps2_line_ready, commit_overrun and the input_made history register to 0.
  - State to EDIT.
  - A reset mid-line discards the partial line.
- Key detection:
  - A key event is registered at the edge where input_made is 1 and the registered previous value is 0.
  - Exactly one event per rising edge; holding input_made high produces no repeats.
- Key classification, for an event at edge N (effects visible after edge N, latency 1):
  - Printable (8'h20..8'h7E):
    - If edit_length < LINE_CHARS, write at index edit_length and increment.
    - Otherwise drop the character; no state change.
  - Backspace (8'h08):
    - If edit_length > 0, decrement and rewrite that slot to PAD_CHAR.
    - At 0, no-op.
  - Enter (8'h0D), see the commit rules below.
  - Any other code is ignored.
- State machine: two states, EDIT (ps2_line_ready = 0) and HOLD (ps2_line_ready = 1).
  - EDIT + Enter with edit_length > 0:
    - ps2_line_content <= edit_content; ps2_line_ready <= 1.
    - edit_content cleared to PAD_CHAR; edit_length <= 0.
    - Go to HOLD.
  - Enter with edit_length == 0 (either state): ignored. No commit and no overrun.
  - HOLD + line_ack = 1: ps2_line_ready <= 0, go to EDIT. ps2_line_content keeps its value.
  - HOLD + Enter with a non-empty line and no line_ack in the same cycle:
    - The Enter is dropped; the edit buffer is kept.
    - commit_overrun <= 1, sticky until reset.
  - Simultaneous line_ack and non-empty Enter in HOLD:
    - The ack is processed first, then the new line commits in the same edge.
    - ps2_line_ready stays 1, state stays HOLD, ps2_line_content takes the new line, no overrun.
  - line_ack in EDIT is ignored.
  - Editing (printable and backspace) is accepted in both states.
- line_full is combinational from edit_length.
- All other outputs are registered.

Optional Feature:
- Macro: PS2_LINE_UPPERCASE_EN.
  - Defined: printable codes 8'h61..8'h7A ('a'..'z') are stored minus 8'h20 (uppercase). Other codes are unchanged.
  - Undefined: characters are stored exactly as received.
- Classification (printable/backspace/Enter) is identical in both builds.

Test Plan:
- Reset, then type 'H','I' (8'h48, 8'h49) as single-cycle input_made pulses, then Enter:
  - edit_length goes 1 then 2.
  - After Enter: ps2_line_content top bytes are 4849 with the remaining 30 bytes 20, ps2_line_ready=1, edit_length=0, edit_content all 20.
- Type 'A','B', backspace, 'C', Enter: committed top bytes are 4143, rest 20. Backspace at length 0 leaves length at 0.
- Hold input_made high for 10 cycles with 8'h41: exactly one 'A' is stored (edit_length=1).
- Type 33 printable keys: edit_length saturates at 32, line_full=1 after the 32nd key, and the 33rd key leaves edit_content unchanged.
- Commit "X" (ps2_line_ready=1, no ack), type "Y", Enter:
  - commit_overrun=1, ps2_line_content still holds "X", edit_length=1.
  - Then pulse line_ack on the same cycle as a second Enter: ps2_line_content holds "Y", ps2_line_ready stays 1, edit_length=0.
- Assert reset mid-line after 3 characters while ps2_line_ready=1: all outputs return to reset values immediately, without waiting for a clock edge. With PS2_LINE_UPPERCASE_EN defined, typing 'q' (8'h71) stores 8'h51.
